// File: rtl/tdm_mux8x1.sv
// tdm_mux8x1: merges eight valid/ready channels onto one registered output
// stream. Each output beat carries its source channel code on out_sel, which
// drives the select of the downstream 1x8 demultiplexer. A round-robin pointer
// keeps service fair. The output register can drain and reload in the same
// cycle, so the stream sustains one beat per clock.
module tdm_mux8x1 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready
);

  // Channel most recently granted. A channel moves to lowest priority once it
  // has been served.
  logic [2:0] ptr;

  // The output register can take a new beat if it is empty, or if it is
  // draining in this cycle.
  logic       load;

  // Result of the round-robin search.
  logic       gnt_any;
  logic [2:0] gnt_idx;
  logic [2:0] cand;

  assign load = !out_valid || out_ready;

  // Round-robin search from ptr+1 upward, wrapping 7->0. The search uses only
  // the valid bits, so the grant never depends on the data.
  always_comb begin
    // NOTE: every variable gets a default before any branch. Without a
    // default, a path that skips an assignment makes the tool infer a latch.
    gnt_any  = 1'b0;
    gnt_idx  = 3'd0;
    cand     = 3'd0;
    in_ready = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!gnt_any && in_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // A grant needs room in the output register and no reset in progress.
    if (rst || !load) begin
      gnt_any = 1'b0;
    end
    if (gnt_any) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register and priority pointer. The register loads a granted beat,
  // empties when it drains with nothing to replace it, and holds while stalled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, whatever the statement order.
    if (rst) begin
      // NOTE: out_data and out_sel are reset as well as out_valid. They are
      // plain registers, not a memory array, so a reset costs little, and
      // downstream logic that looks at them while idle sees a known value.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ptr       <= 3'd7;
    end else if (gnt_any) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*DATA_W +: DATA_W];
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux8x1.sv
// Directed bench for tdm_mux8x1. Inputs change 1 time unit after the rising
// edge. Registered outputs and the combinational in_ready are sampled at that
// point, once the inputs for the coming edge have settled.
module tb_tdm_mux8x1;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          in_valid;
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic                out_ready;

  int vectors     = 0;
  int miscompares = 0;

  tdm_mux8x1 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Place one beat on channel k's data lane.
  task automatic set_data(input int k, input logic [DATA_W-1:0] v);
    in_data[k*DATA_W +: DATA_W] = v;
  endtask

  // Check all three output-register fields.
  task automatic check_out(input string tag, input logic v, input logic [2:0] s,
                           input logic [DATA_W-1:0] d);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
    check({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 8'hFF;
    in_data   = '0;
    out_ready = 1'b0;

    // 1: reset held two cycles. All channels request, but in_ready stays 0.
    tick();
    tick();
    check_out("reset", 1'b0, 3'd0, 8'h00);
    check("reset.in_ready", 32'(in_ready), 32'h00);

    // 2: single channel 3. Accepted this cycle, visible on the next cycle.
    rst       = 1'b0;
    in_valid  = 8'h08;
    set_data(3, 8'hA5);
    out_ready = 1'b1;
    #1;
    check("single.in_ready", 32'(in_ready), 32'h08);
    tick();
    in_valid = 8'h00;
    check_out("single.out", 1'b1, 3'd3, 8'hA5);
    // Drains with no new grant: valid drops, data and sel keep their values.
    tick();
    check_out("single.drain", 1'b0, 3'd3, 8'hA5);

    // 3: reset so that ptr=7, then all eight request with data = channel.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) set_data(k, DATA_W'(k));
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i <= 8; i++) begin
      check($sformatf("rr%0d.in_ready", i), 32'(in_ready), 32'(8'h01 << (i % 8)));
      tick();
      check_out($sformatf("rr%0d", i), 1'b1, 3'(i % 8), 8'(i % 8));
    end
    // ptr is now 0.

    // 4: load a beat from ch5, then stall it for 4 cycles while ch2 requests.
    in_valid = 8'h20;
    set_data(5, 8'h3C);
    set_data(2, 8'h22);
    #1;
    check("stall.grant5", 32'(in_ready), 32'h20);
    tick();
    check_out("stall.load", 1'b1, 3'd5, 8'h3C);
    in_valid  = 8'h04;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'h00);
      tick();
      check_out($sformatf("stall%0d", i), 1'b1, 3'd5, 8'h3C);
    end
    out_ready = 1'b1;
    #1;
    check("stall.release", 32'(in_ready), 32'h04);
    tick();
    check_out("stall.next", 1'b1, 3'd2, 8'h22);

    // 5: grant ch6, then ch7 and ch0 request: ch7 wins, then ch0 after the wrap.
    in_valid = 8'h40;
    set_data(6, 8'h66);
    tick();
    check_out("wrap.ch6", 1'b1, 3'd6, 8'h66);
    in_valid = 8'h81;
    set_data(7, 8'h77);
    set_data(0, 8'h10);
    #1;
    check("wrap.grant7", 32'(in_ready), 32'h80);
    tick();
    check_out("wrap.ch7", 1'b1, 3'd7, 8'h77);
    check("wrap.grant0", 32'(in_ready), 32'h01);
    tick();
    check_out("wrap.ch0", 1'b1, 3'd0, 8'h10);
    in_valid = 8'h00;
    tick();
    check("wrap.idle", 32'(out_valid), 32'h0);

    // 6: reset during a stall. The beat is dropped, and ptr=7 gives ch0 the win over ch4.
    in_valid = 8'h08;
    set_data(3, 8'h33);
    tick();
    check_out("rststall.load", 1'b1, 3'd3, 8'h33);
    in_valid  = 8'h00;
    out_ready = 1'b0;
    tick();
    check_out("rststall.hold", 1'b1, 3'd3, 8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rststall.reset", 1'b0, 3'd0, 8'h00);
    in_valid  = 8'h11;
    set_data(0, 8'hC0);
    set_data(4, 8'hC4);
    out_ready = 1'b1;
    #1;
    check("rststall.grant", 32'(in_ready), 32'h01);
    tick();
    check_out("rststall.first", 1'b1, 3'd0, 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
